// File: rtl/crypto_outgoing_reader.sv
// Avalon-MM read master draining the crypto outgoing memory into a single Avalon-ST packet.
// Reads are issued only when the output FIFO has room reserved for the returning word.
module crypto_outgoing_reader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 4089,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_clken,
   output logic                  mem_write,
   output logic [3:0]            mem_byteenable,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   output logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_valid,
   input  logic                  src_ready,
   output logic                  src_startofpacket,
   output logic                  src_endofpacket
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int NW = ADDR_WIDTH + 1;
   localparam int RW = ADDR_WIDTH + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [NW-1:0]         count;
   logic [NW-1:0]         issued;
   logic [NW-1:0]         accepted;
   logic                  inflight;
   logic                  done_q;
   logic                  error_q;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         occ;

   logic                  active;
   logic                  kill;
   logic [RW-1:0]         range_end;
   logic                  range_bad;
   logic                  space;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  last_pop;

   always_comb begin
      active    = (state != S_IDLE);
      kill      = active && abort;
      range_end = {2'b00, start_addr} + {1'b0, word_count};
      range_bad = (word_count == '0) || (range_end > RW'(MEM_WORDS));
      // Occupancy plus the word still in flight must leave a free slot before issuing.
      space     = (({1'b0, occ} + {{CW{1'b0}}, inflight}) < (CW + 1)'(FIFO_DEPTH));
      issue     = (state == S_READ) && space && !abort;
      push      = inflight;
      pop       = src_valid && src_ready;
      last_pop  = pop && (accepted == (count - 1'b1));
   end

   // Control FSM and transfer counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         addr     <= '0;
         count    <= '0;
         issued   <= '0;
         accepted <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (kill) begin
            state    <= S_IDLE;
            addr     <= '0;
            issued   <= '0;
            accepted <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (range_bad) begin
                        error_q <= 1'b1;
                     end else begin
                        state    <= S_READ;
                        addr     <= start_addr;
                        count    <= word_count;
                        issued   <= '0;
                        accepted <= '0;
                     end
                  end
               end
               S_READ: begin
                  if (issue) begin
                     addr   <= addr + 1'b1;
                     issued <= issued + 1'b1;
                     if ((issued + 1'b1) == count) begin
                        state <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
               end
               default: state <= S_IDLE;
            endcase

            if (pop) begin
               accepted <= accepted + 1'b1;
            end
            if (last_pop) begin
               state  <= S_IDLE;
               done_q <= 1'b1;
            end
         end
      end
   end

   // Output FIFO: a returning word is always written, its slot was reserved at issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         inflight <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else if (kill) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (push) begin
            fifo_mem[wr_ptr] <= mem_readdata;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_comb begin
      busy              = active;
      done              = done_q;
      error             = error_q;
      mem_address       = addr;
      mem_chipselect    = issue;
      mem_clken         = 1'b1;
      mem_write         = 1'b0;
      mem_byteenable    = 4'hF;
      src_valid         = (occ != '0);
      src_data          = fifo_mem[rd_ptr];
      src_startofpacket = src_valid && (accepted == '0);
      src_endofpacket   = src_valid && (accepted == (count - 1'b1));
   end

endmodule

// File: tb/tb_crypto_outgoing_reader.sv
// Scoreboard bench for crypto_outgoing_reader: stimulus pushes expected strobes, words and
// pulses into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_crypto_outgoing_reader;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int MW = 4089;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   word_count;
   logic          abort;
   logic          busy, done, error;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect, mem_clken, mem_write;
   logic [3:0]    mem_byteenable;
   logic [DW-1:0] mem_readdata;
   logic [DW-1:0] src_data;
   logic          src_valid, src_ready, src_startofpacket, src_endofpacket;

   crypto_outgoing_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .word_count(word_count), .abort(abort), .busy(busy), .done(done), .error(error),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
      .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      bit            sop;
      bit            eop;
      int            cyc;
   } word_t;

   logic [DW-1:0] mem_model [MW];
   word_t exp_words [$];
   int    exp_addr  [$];
   int    exp_done  [$];
   int    exp_err   [$];

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int out_cnt = 0;
   int pops   = 0;
   int last_eop_cyc = -10;
   int mode   = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data;

   // One-cycle-latency single-port RAM model
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_chipselect) begin
         if (int'(mem_address) < MW) mem_readdata <= mem_model[mem_address];
         else mem_readdata <= 'x;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Ready driver: 0 = low, 1 = high, 2 = toggle, 3 = random
   initial begin
      src_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: src_ready = 1'b0;
            1: src_ready = 1'b1;
            2: src_ready = ~src_ready;
            default: src_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 0;
      end else begin
         check("mem_clken", mem_clken, 1);
         check("mem_write", mem_write, 0);
         check("mem_byteenable", mem_byteenable, 4'hF);
         if (mem_chipselect) begin
            check("outstanding below depth", out_cnt < FD, 1);
            check("strobe expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) check("strobe address", mem_address, exp_addr.pop_front());
            out_cnt++;
         end
         if (src_valid && prev_stall) check("data stable while stalled", src_data, prev_data);
         if (src_valid && src_ready) begin
            word_t w;
            out_cnt--;
            pops++;
            check("word expected", exp_words.size() > 0, 1);
            if (exp_words.size() > 0) begin
               w = exp_words.pop_front();
               check("src_data", src_data, w.data);
               check("src_startofpacket", src_startofpacket, w.sop);
               check("src_endofpacket", src_endofpacket, w.eop);
               if (w.cyc >= 0) check("word cycle", cyc, w.cyc);
               if (w.eop) last_eop_cyc = cyc;
            end
         end
         prev_stall = src_valid && !src_ready;
         prev_data  = src_data;
         if (done) begin
            check("done expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
               void'(exp_done.pop_front());
               check("done cycle", cyc, last_eop_cyc + 1);
            end
            check("busy low with done", busy, 0);
         end
         if (error) begin
            check("error expected", exp_err.size() > 0, 1);
            if (exp_err.size() > 0) check("error cycle", cyc, exp_err.pop_front());
            check("busy low with error", busy, 0);
         end
      end
   end

   task automatic flush();
      exp_words.delete();
      exp_addr.delete();
      exp_done.delete();
      exp_err.delete();
      out_cnt = 0;
   endtask

   // Reference model: a legal start yields words mem[sa..sa+wc-1] as one packet
   task automatic do_start(input int sa, input int wc, input bit busy_now, input bit timed);
      int e;
      word_t w;
      @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = AW'(sa);
      word_count = (AW + 1)'(wc);
      e = cyc;
      if (!busy_now) begin
         if (wc == 0 || sa + wc > MW) begin
            exp_err.push_back(e + 1);
         end else begin
            for (int k = 0; k < wc; k++) begin
               exp_addr.push_back(sa + k);
               w.data = mem_model[sa + k];
               w.sop  = (k == 0);
               w.eop  = (k == wc - 1);
               w.cyc  = timed ? e + 3 + k : -1;
               exp_words.push_back(w);
            end
            exp_done.push_back(1);
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      int left;
      left = exp_words.size() + exp_addr.size() + exp_done.size() + exp_err.size();
      while (left != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         left = exp_words.size() + exp_addr.size() + exp_done.size() + exp_err.size();
      end
      check("completion within budget", left, 0);
      if (left != 0) flush();
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " error"}, error, 0);
      check({tag, " mem_chipselect"}, mem_chipselect, 0);
      check({tag, " src_valid"}, src_valid, 0);
      check({tag, " sop"}, src_startofpacket, 0);
      check({tag, " eop"}, src_endofpacket, 0);
      check({tag, " mem_address"}, mem_address, 0);
      check({tag, " src_data"}, src_data, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sa, wc, base, n;
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      start_addr = '0;
      word_count = '0;
      for (int k = 0; k < MW; k++) mem_model[k] = 32'hA500_0000 + k;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      check("reset mem_clken", mem_clken, 1);
      check("reset mem_byteenable", mem_byteenable, 4'hF);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Basic 8-word transfer, ready held high, exact cycle timing
      mode = 1;
      do_start(16, 8, 0, 1);
      wait_idle(100);

      // Same transfer with ready toggling
      mode = 2;
      do_start(16, 8, 0, 0);
      wait_idle(200);

      // Last-word boundary and range rejections
      mode = 1;
      do_start(4088, 1, 0, 1);
      wait_idle(50);
      do_start(4088, 2, 0, 0);
      wait_idle(20);
      do_start(5, 0, 0, 0);
      wait_idle(20);

      // Start while busy is ignored
      mode = 3;
      do_start(256, 20, 0, 0);
      repeat (5) @(posedge clk);
      do_start(768, 5, 1, 0);
      wait_idle(300);

      // Whole memory in one packet
      mode = 1;
      do_start(0, MW, 0, 0);
      wait_idle(MW + 50);

      // Abort after three words, then a clean restart
      mode = 1;
      base = pops;
      do_start(200, 100, 0, 0);
      n = 0;
      while (pops - base < 3 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("three words before abort", pops - base, 3);
      mode = 0;
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("busy after abort", busy, 0);
      check("src_valid after abort", src_valid, 0);
      flush();
      repeat (6) @(posedge clk);
      mode = 3;
      do_start(300, 12, 0, 0);
      wait_idle(200);

      // Randomised transfers over fresh memory contents
      for (int k = 0; k < MW; k++) mem_model[k] = $urandom;
      for (int t = 0; t < 10; t++) begin
         mode = 2 + int'($urandom_range(0, 1));
         sa = int'($urandom_range(0, MW - 1));
         wc = int'($urandom_range(1, 40));
         if (sa + wc > MW) wc = MW - sa;
         if ($urandom_range(0, 4) == 0) wc = MW - sa + 1;
         do_start(sa, wc, 0, 0);
         wait_idle(400);
      end

      // Asynchronous reset mid-transfer
      mode = 3;
      do_start(50, 60, 0, 0);
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs("async reset");
      flush();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fifo empty after reset", src_valid, 0);
         check("idle after reset", busy, 0);
      end
      mode = 1;
      do_start(1000, 6, 0, 1);
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
